// File: rtl/user_module_pattern_shifter.sv
// ---------------------------------------------------------------------------
// user_module_pattern_shifter
//
// Purpose:
//    Serial 3-bit pattern detector for a TinyTapeout slot. Enabled input bits
//    shift into a 3-bit window. Once three bits have been shifted since reset,
//    the detector compares the window against 1-0-1 (psel=0) or 0-1-0 (psel=1).
//    Both patterns are read oldest to newest. A match produces a registered
//    one-cycle pulse, sets a sticky "seen" flag and bumps a saturating match
//    counter. Overlapping patterns are detected.
//
// Ports:
//    io_in[0]    clk   - single clock, rising edge
//    io_in[1]    rst   - synchronous active-high reset
//    io_in[2]    din   - serial data bit
//    io_in[3]    en    - shift enable (din sampled only when 1)
//    io_in[4]    psel  - pattern select (0: 1-0-1, 1: 0-1-0)
//    io_in[5]    clr   - synchronous clear of count and seen
//    io_in[7:6]  unused
//    io_out[0]   match - one-cycle match pulse
//    io_out[4:1] count - saturating match count
//    io_out[5]   seen  - sticky match flag
//    io_out[7:6] state - 00 EMPTY, 01 FILL, 10 ARMED
//
// Configuration:
//    PATTERN_SHIFTER_COUNT_EN - when defined, builds the 4-bit match counter.
//    When it is undefined, io_out[4:1] is tied to zero and no counter flops
//    exist.
// ---------------------------------------------------------------------------
module user_module_pattern_shifter (
   input  logic [7:0] io_in,
   output logic [7:0] io_out
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'b00,
      ST_FILL  = 2'b01,
      ST_ARMED = 2'b10
   } state_t;

   logic clk;
   logic rst;
   logic din;
   logic en;
   logic psel;
   logic clr;
   logic unused_in;

   assign clk       = io_in[0];
   assign rst       = io_in[1];
   assign din       = io_in[2];
   assign en        = io_in[3];
   assign psel      = io_in[4];
   assign clr       = io_in[5];
   assign unused_in = ^io_in[7:6];

   logic [2:0] w_q, w_d;
   logic [1:0] cnt_q, cnt_d;
   state_t     state_q, state_d;
   logic       match_q, match_d;
   logic       seen_q, seen_d;
   logic [2:0] pattern;
   logic [3:0] count_out;

   // Window shift and the saturating count of enabled shifts since reset.
   // The match decision looks at the post-shift window and post-shift count,
   // so the third qualifying bit can produce a match on the same edge.
   always_comb begin
      w_d     = w_q;
      cnt_d   = cnt_q;
      pattern = psel ? 3'b010 : 3'b101;
      if (en) begin
         w_d = {w_q[1:0], din};
         if (cnt_q != 2'd3) begin
            cnt_d = cnt_q + 2'd1;
         end
      end
      match_d = en && (w_d == pattern) && (cnt_d == 2'd3);
   end

   // Fill FSM: it leaves EMPTY on the first enabled shift and reaches ARMED on
   // the third. ARMED is held until reset, so it tracks cnt == 3 exactly.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_EMPTY: if (en) state_d = ST_FILL;
         ST_FILL:  if (en && cnt_q == 2'd2) state_d = ST_ARMED;
         ST_ARMED: state_d = ST_ARMED;
         default:  state_d = ST_EMPTY;
      endcase
   end

   // clr takes priority over a simultaneous set of the sticky flag.
   always_comb begin
      seen_d = seen_q | match_d;
      if (clr) begin
         seen_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         w_q     <= 3'b000;
         cnt_q   <= 2'd0;
         state_q <= ST_EMPTY;
         match_q <= 1'b0;
         seen_q  <= 1'b0;
      end else begin
         w_q     <= w_d;
         cnt_q   <= cnt_d;
         state_q <= state_d;
         match_q <= match_d;
         seen_q  <= seen_d;
      end
   end

`ifdef PATTERN_SHIFTER_COUNT_EN
   logic [3:0] count_q, count_d;

   // Saturating match counter. clr overrides an increment on the same edge.
   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = 4'd0;
      end else if (match_d && count_q != 4'd15) begin
         count_d = count_q + 4'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= 4'd0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_out = count_q;
`else
   assign count_out = 4'd0;
`endif

   assign io_out = {state_q, seen_q, count_out, match_q};

endmodule

// File: tb/tb_user_module_pattern_shifter.sv
// ---------------------------------------------------------------------------
// tb_user_module_pattern_shifter
//
// Purpose:
//    Self-checking bench for user_module_pattern_shifter. The bench has three
//    parts:
//      - a table of hand-derived vectors covering reset, basic detect, clear
//        and clear priority, and reset mid-pattern;
//      - hand-written sequences covering enable gaps with overlap, and count
//        saturation;
//      - randomized stimulus checked against a history-based reference model.
//
// Configuration:
//    Honors PATTERN_SHIFTER_COUNT_EN the same way as the design. When the
//    macro is undefined, the expected count is always zero.
// ---------------------------------------------------------------------------
module tb_user_module_pattern_shifter;

   logic       clk;
   logic       rst;
   logic       din;
   logic       en;
   logic       psel;
   logic       clr;
   logic [1:0] ign;
   logic [7:0] io_in;
   logic [7:0] io_out;

   int errors;
   int checks;

   // Reference model: the enabled bits seen since reset, plus the outputs.
   bit         hist[$];
   int         nshift;
   bit         m_match;
   int         m_count;
   bit         m_seen;

   assign io_in = {ign, clr, psel, en, din, rst, clk};

   user_module_pattern_shifter dut (
      .io_in  (io_in),
      .io_out (io_out)
   );

   // Free-running clock on io_in[0].
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      string      name;
      logic       rst;
      logic       din;
      logic       en;
      logic       psel;
      logic       clr;
      logic [7:0] expOut;
   } vec_t;

   // Builds the output byte the model predicts, from the spec's rules.
   function automatic logic [7:0] modelOut();
      logic [1:0] st;
      logic [3:0] cnt;
      if (nshift == 0)     st = 2'b00;
      else if (nshift < 3) st = 2'b01;
      else                 st = 2'b10;
`ifdef PATTERN_SHIFTER_COUNT_EN
      cnt = 4'(m_count);
`else
      cnt = 4'd0;
`endif
      return {st, m_seen, cnt, m_match};
   endfunction

   // Removes the count field when the counter is not built.
   function automatic logic [7:0] adjustExp(input logic [7:0] e);
`ifdef PATTERN_SHIFTER_COUNT_EN
      return e;
`else
      return e & 8'hE1;
`endif
   endfunction

   // Advances the model by one clock edge with the given inputs.
   task automatic modelEdge(input logic r, input logic d, input logic e,
                            input logic p, input logic c);
      bit pat[3];
      if (r) begin
         hist.delete();
         nshift  = 0;
         m_match = 0;
         m_count = 0;
         m_seen  = 0;
      end else begin
         if (e) begin
            hist.push_back(d);
            if (hist.size() > 3) void'(hist.pop_front());
            nshift++;
         end
         if (p) begin pat[0] = 0; pat[1] = 1; pat[2] = 0; end
         else   begin pat[0] = 1; pat[1] = 0; pat[2] = 1; end
         m_match = e && nshift >= 3 && hist[0] == pat[0]
                   && hist[1] == pat[1] && hist[2] == pat[2];
         if (c) m_count = 0;
         else if (m_match && m_count < 15) m_count++;
         if (c) m_seen = 0;
         else   m_seen = m_seen | m_match;
      end
   endtask

   // Drives one edge worth of inputs, keeps the model in step, and then
   // settles 1ns past the edge so io_out can be sampled.
   task automatic applyStimulus(input logic r, input logic d, input logic e,
                                input logic p, input logic c);
      rst  = r;
      din  = d;
      en   = e;
      psel = p;
      clr  = c;
      @(posedge clk);
      modelEdge(r, d, e, p, c);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [7:0] expected);
      checks++;
      if (io_out !== expected) begin
         errors++;
         $display("[TB] FAIL %s: io_out=0x%02h expected=0x%02h", name, io_out, expected);
      end
   endtask

   vec_t vecs[$];

   initial begin
      errors  = 0;
      checks  = 0;
      nshift  = 0;
      m_match = 0;
      m_count = 0;
      m_seen  = 0;
      rst = 1; din = 0; en = 0; psel = 0; clr = 0; ign = 2'b00;

      // Hand-derived table: name, rst, din, en, psel, clr, expected io_out.
      vecs.push_back('{"reset",          1, 0, 0, 0, 0, 8'h00});
      vecs.push_back('{"basic_bit1",     0, 1, 1, 0, 0, 8'h40});
      vecs.push_back('{"basic_bit2",     0, 0, 1, 0, 0, 8'h40});
      vecs.push_back('{"basic_bit3",     0, 1, 1, 0, 0, 8'hA3});
      vecs.push_back('{"basic_hold",     0, 0, 0, 0, 0, 8'hA2});
      vecs.push_back('{"clr_nomatch",    0, 0, 1, 0, 1, 8'h80});
      vecs.push_back('{"rematch",        0, 1, 1, 0, 0, 8'hA3});
      vecs.push_back('{"shift0",         0, 0, 1, 0, 0, 8'hA2});
      vecs.push_back('{"clr_priority",   0, 1, 1, 0, 1, 8'h81});
      vecs.push_back('{"reset2",         1, 1, 1, 0, 1, 8'h00});
      vecs.push_back('{"mid_bit1",       0, 1, 1, 0, 0, 8'h40});
      vecs.push_back('{"mid_bit2",       0, 0, 1, 0, 0, 8'h40});
      vecs.push_back('{"mid_reset",      1, 0, 1, 0, 0, 8'h00});
      vecs.push_back('{"mid_after",      0, 1, 1, 0, 0, 8'h40});

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i].rst, vecs[i].din, vecs[i].en, vecs[i].psel, vecs[i].clr);
         checkOutput(vecs[i].name, adjustExp(vecs[i].expOut));
      end

      // Overlap with an enable gap between bits 2 and 3: 1,0,(gap x2),1,0,1.
      applyStimulus(1, 0, 0, 0, 0);
      checkOutput("gap_reset", 8'h00);
      applyStimulus(0, 1, 1, 0, 0);
      applyStimulus(0, 0, 1, 0, 0);
      applyStimulus(0, 1, 0, 0, 0);
      checkOutput("gap_nomatch1", 8'h40);
      applyStimulus(0, 1, 0, 0, 0);
      checkOutput("gap_nomatch2", 8'h40);
      applyStimulus(0, 1, 1, 0, 0);
      checkOutput("gap_match1", adjustExp(8'hA3));
      applyStimulus(0, 0, 1, 0, 0);
      checkOutput("gap_between", adjustExp(8'hA2));
      applyStimulus(0, 1, 1, 0, 0);
      checkOutput("gap_match2", adjustExp(8'hA5));

      // Saturation: psel=1 with an alternating 0,1,0,1,... stream matches on
      // every second bit from bit 3 onward, which gives 20 matches in 41 bits.
      applyStimulus(1, 0, 0, 1, 0);
      for (int i = 0; i < 41; i++) begin
         applyStimulus(0, logic'(i % 2), 1, 1, 0);
         checkOutput("sat_model", modelOut());
      end
`ifdef PATTERN_SHIFTER_COUNT_EN
      checkOutput("sat_final", 8'hBF);
`else
      checkOutput("sat_final", 8'hA1);
`endif

      // Randomized activity checked against the model. io_in[7:6] toggles too.
      for (int i = 0; i < 400; i++) begin
         ign = 2'($urandom_range(0, 3));
         applyStimulus(logic'($urandom_range(0, 29) == 0), logic'($urandom_range(0, 1)),
                       logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 7) == 0),
                       logic'($urandom_range(0, 24) == 0));
         checkOutput("random", modelOut());
      end

      // Reset after random activity clears every output.
      applyStimulus(1, 1, 1, 1, 0);
      checkOutput("reset_after_random", 8'h00);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/user_module_pattern_shifter.md
USER_MODULE_PATTERN_SHIFTER -- requirements
Module: user_module_pattern_shifter

Interface
REQ-001 SHALL have port io_in  input  8  packed TinyTapeout input bus, bit map REQ-003..REQ-008.
REQ-002 SHALL have port io_out  output  8  packed TinyTapeout output bus, bit map REQ-009..REQ-012.
REQ-003 SHALL use io_in[0]  input  1  clk: the single clock; all state updates on its rising edge.
REQ-004 SHALL use io_in[1]  input  1  rst: synchronous, active-high reset.
REQ-005 SHALL use io_in[2]  input  1  din: serial data bit.
REQ-006 SHALL use io_in[3]  input  1  en: shift enable; din is sampled only when en=1.
REQ-007 SHALL use io_in[4]  input  1  psel: pattern select; 0 selects 1-0-1, 1 selects 0-1-0 (oldest to newest).
REQ-008 SHALL use io_in[5]  input  1  clr: synchronous clear of count and seen; io_in[7:6] are ignored.
REQ-009 SHALL drive io_out[0]  output  1  match: registered one-cycle pulse.
REQ-010 SHALL drive io_out[4:1]  output  4  count: saturating match count.
REQ-011 SHALL drive io_out[5]  output  1  seen: sticky flag, set by any match.
REQ-012 SHALL drive io_out[7:6]  output  2  state: 00 EMPTY, 01 FILL, 10 ARMED; 11 is never driven.

Function
REQ-013 SHALL hold a 3-bit window w[2:0], w[2] oldest; on an edge with en=1, w <= {w[1:0], din}; with en=0, w is held.
REQ-014 SHALL run a fill FSM: EMPTY -> FILL on the first enabled shift; FILL -> ARMED on the third enabled shift since reset; ARMED is terminal until reset.
REQ-015 SHALL keep a 2-bit shift counter saturating at 3; state is ARMED exactly when counter = 3.
REQ-016 SHALL, on each edge, set match <= en AND (post-shift window == selected pattern) AND (post-shift counter = 3); otherwise match <= 0.
REQ-017 SHALL assert match the cycle after the third qualifying bit is sampled (latency 1 clock from sampling edge to visible output).
REQ-018 SHALL detect overlapping patterns: input 1,0,1,0,1 with psel=0 yields two match pulses, on the cycles after bits 3 and 5.
REQ-019 SHALL evaluate psel combinationally at each sampling edge; a psel change does not flush the window.
REQ-020 SHALL increment count on every edge where match is set to 1, saturating at 15 (no wrap).
REQ-021 SHALL set seen on the edge where match is set to 1; seen remains set until rst or clr.
REQ-022 SHALL, when clr=1, force count=0 and seen=0 on that edge, overriding a simultaneous increment or set; window, FSM and match are unaffected.

Reset
REQ-023 SHALL, on an edge with rst=1, force w=000, shift counter=0, state=EMPTY, match=0, count=0, seen=0, overriding en, clr and din.
REQ-024 SHALL, on reset mid-stream, discard partial patterns; detection requires three new enabled shifts.

Configuration
REQ-025 SHALL compile the match counter only when macro PATTERN_SHIFTER_COUNT_EN is defined.
REQ-026 SHALL, when PATTERN_SHIFTER_COUNT_EN is undefined, tie io_out[4:1] to 0000 with no counter flops; all other behaviour is unchanged.

Verification
REQ-027 SHALL verify reset: rst=1 for one edge after random activity -> io_out = 0x00 on the next cycle.
REQ-028 SHALL verify basic detect: psel=0, en=1, din 1,0,1 -> state 01,01,10; match=1 for exactly one cycle after bit 3; count=1; seen=1.
REQ-029 SHALL verify overlap and enable gaps: din 1,0,1,0,1 with en=0 for two cycles between bits 2 and 3 -> two match pulses, count=2, no match during the gap.
REQ-030 SHALL verify saturation: 20 consecutive 0-1-0 matches with psel=1 -> count stays at 15 (with PATTERN_SHIFTER_COUNT_EN), or stays at 0 (without it).
REQ-031 SHALL verify clear priority: clr=1 on the same edge that match rises -> match=1, count=0, seen=0 on the next cycle.
REQ-032 SHALL verify reset mid-pattern: bits 1,0, then rst, then bit 1 -> no match; state=01.
